// File: rtl/quad_step_decoder.sv
// ---------------------------------------------------------------------------
// quad_step_decoder
//
// Front-end for the 4-bit up/down counter. It takes the raw asynchronous
// quadrature channels A/B and produces one-cycle step pulses plus a direction
// bit. step drives the counter enable and dir drives its up_down input.
//
// Processing chain:
//   2-flop synchroniser -> per-channel glitch filter -> Gray decoder
//   -> registered outputs
//
// Parameters:
//   FILTER_CYCLES  consecutive cycles a synchronised channel must differ from
//                  its filtered value before the filtered value flips (1..15)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   quad_a     raw encoder channel A (asynchronous)
//   quad_b     raw encoder channel B (asynchronous)
//   enable     output gate; tracking continues while low
//   step       one-cycle pulse per legal quadrature transition
//   dir        1 = up (A leads B), 0 = down; holds its last value between steps
//   err        one-cycle pulse when both channels change on the same edge
//   err_count  (only with QUAD_ERR_COUNT_EN defined) saturating 8-bit count
//              of err pulses, cleared only by reset
//
// Optional feature macro: QUAD_ERR_COUNT_EN
// ---------------------------------------------------------------------------
module quad_step_decoder #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       quad_a,
  input  logic       quad_b,
  input  logic       enable,
  output logic       step,
  output logic       dir,
`ifdef QUAD_ERR_COUNT_EN
  output logic       err,
  output logic [7:0] err_count
`else
  output logic       err
`endif
);

  localparam logic [3:0] FILT_LAST = 4'(FILTER_CYCLES - 1);

  // Next {filtered, counter} for one channel. The counter only runs while the
  // synchronised value disagrees with the filtered one; reaching FILT_LAST
  // while still disagreeing commits the new value.
  function automatic logic [4:0] filter_next(input logic       synced,
                                             input logic       filt,
                                             input logic [3:0] cnt);
    logic [4:0] res;
    if (synced == filt) begin
      res = {filt, 4'd0};
    end else if (cnt == FILT_LAST) begin
      res = {synced, 4'd0};
    end else begin
      res = {filt, cnt + 4'd1};
    end
    return res;
  endfunction

  // Saturating increment for the 8-bit error counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic       a_p0, a_p1, b_p0, b_p1;
  logic       filt_a_p2, filt_b_p2;
  logic [3:0] cnt_a_p2, cnt_b_p2;
  logic [1:0] prev_p3;
  logic [4:0] nxt_a, nxt_b;
  logic [1:0] state;
  logic       moved, double_move, single_move, up_move;

  // Stage p0/p1: two-flop synchroniser per channel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_p0 <= 1'b0;
      a_p1 <= 1'b0;
      b_p0 <= 1'b0;
      b_p1 <= 1'b0;
    end else begin
      a_p0 <= quad_a;
      a_p1 <= a_p0;
      b_p0 <= quad_b;
      b_p1 <= b_p0;
    end
  end

  // Stage p2: independent glitch filters on the synchronised channels
  always_comb begin
    nxt_a = filter_next(a_p1, filt_a_p2, cnt_a_p2);
    nxt_b = filter_next(b_p1, filt_b_p2, cnt_b_p2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_a_p2 <= 1'b0;
      cnt_a_p2  <= 4'd0;
      filt_b_p2 <= 1'b0;
      cnt_b_p2  <= 4'd0;
    end else begin
      filt_a_p2 <= nxt_a[4];
      cnt_a_p2  <= nxt_a[3:0];
      filt_b_p2 <= nxt_b[4];
      cnt_b_p2  <= nxt_b[3:0];
    end
  end

  // Stage p3: Gray decode of {A,B} against the previous state.
  // In the up order (00->10->11->01->00) the new A always differs from the
  // old B; in the down order it always matches, so one XOR gives direction.
  always_comb begin
    state       = {filt_a_p2, filt_b_p2};
    moved       = (state != prev_p3);
    double_move = &(state ^ prev_p3);
    single_move = moved && !double_move;
    up_move     = state[1] ^ prev_p3[0];
  end

  // prev always follows state, so a double move resynchronises immediately.
  // dir keeps tracking while enable is low so re-enabling is seamless.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_p3 <= 2'b00;
      step    <= 1'b0;
      dir     <= 1'b1;
      err     <= 1'b0;
    end else begin
      prev_p3 <= state;
      step    <= enable && single_move;
      err     <= enable && double_move;
      if (single_move) begin
        dir <= up_move;
      end
    end
  end

`ifdef QUAD_ERR_COUNT_EN
  // Stage p4: error counter driven by the gated, registered err pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= 8'd0;
    end else if (err) begin
      err_count <= sat_inc8(err_count);
    end
  end
`endif

endmodule

// File: tb/tb_quad_step_decoder.sv
module tb_quad_step_decoder;

  logic clk = 1'b0;
  logic reset, quad_a, quad_b, enable;
  logic step, dir, err;
`ifdef QUAD_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  quad_step_decoder #(.FILTER_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .quad_a   (quad_a),
    .quad_b   (quad_b),
    .enable   (enable),
    .step     (step),
    .dir      (dir),
`ifdef QUAD_ERR_COUNT_EN
    .err      (err),
    .err_count(err_count)
`else
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic a;
    logic b;
    logic en;
    int   steps;
    logic dir;
    int   errs;
  } vec_t;

  vec_t vecs[16];

  int   total = 0;
  int   passed = 0;
  int   n_steps, n_errs, n_both;
  logic last_dir;
  logic [3:0] counter;
  logic dirs[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clear_obs();
    n_steps = 0;
    n_errs  = 0;
    dirs.delete();
  endtask

  // One clock: sample #1 after the rising edge and feed the downstream
  // counter model with any step pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    if (step) begin
      n_steps++;
      last_dir = dir;
      dirs.push_back(dir);
      counter = dir ? counter + 4'd1 : counter - 4'd1;
    end
    if (err) n_errs++;
    if (step && err) n_both++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_both  = 0;
    counter = 4'd0;
    clear_obs();

    // {a, b, en, steps, dir, errs}
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1, 1'b1, 0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1, 1'b1, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1, 1'b1, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1, 1'b1, 0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1, 1'b0, 0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1, 1'b0, 0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1, 1'b0, 0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1, 1'b0, 0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 0, 1'b0, 1};  // double move: dir unchanged
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1, 1'b1, 0};  // 11->01 is up
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1, 1'b1, 0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 0};  // gated
    vecs[12] = '{1'b1, 1'b1, 1'b0, 0, 1'b1, 0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 0, 1'b1, 0};  // re-enable, static inputs
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1, 1'b1, 0};

    // Reset state
    reset = 1'b1; quad_a = 1'b0; quad_b = 1'b0; enable = 1'b1;
    ticks(3);
    check("reset_step", step, 0);
    check("reset_dir",  dir,  1);
    check("reset_err",  err,  0);
`ifdef QUAD_ERR_COUNT_EN
    check("reset_err_count", err_count, 0);
`endif
    reset = 1'b0;
    ticks(2);

    // First-pulse latency: A edge captured at the next edge, step 6 edges later
    clear_obs();
    quad_a = 1'b1;
    ticks(6);
    check("latency_no_early_step", n_steps, 0);
    tick();
    check("latency_step_at_6", step, 1);
    check("latency_dir", dir, 1);
    ticks(3);
    check("latency_single_pulse", n_steps, 1);
    quad_a = 1'b0;
    ticks(10);
    counter = 4'd0;

    // Table-driven transitions, each held 10 cycles
    for (int i = 0; i < 16; i++) begin
      clear_obs();
      quad_a = vecs[i].a;
      quad_b = vecs[i].b;
      enable = vecs[i].en;
      ticks(10);
      check($sformatf("vec%0d_steps", i), n_steps, vecs[i].steps);
      check($sformatf("vec%0d_errs", i),  n_errs,  vecs[i].errs);
      check($sformatf("vec%0d_dir", i),   dir,     vecs[i].dir);
      if (i == 3) check("counter_after_up", counter, 4);
      if (i == 7) check("counter_after_down", counter, 0);
`ifdef QUAD_ERR_COUNT_EN
      if (i == 9)  check("err_count_after_double", err_count, 1);
      if (i == 13) check("err_count_gated", err_count, 1);
`endif
    end

    // Glitch: 3-cycle pulse on A never reaches the filter
    clear_obs();
    quad_a = 1'b1; ticks(3);
    quad_a = 1'b0; ticks(12);
    check("glitch3_steps", n_steps, 0);
    check("glitch3_errs",  n_errs,  0);

    // 4-cycle pulse passes: up then down
    clear_obs();
    quad_a = 1'b1; ticks(4);
    quad_a = 1'b0; ticks(14);
    check("pulse4_steps", n_steps, 2);
    if (dirs.size() == 2) begin
      check("pulse4_dir_first",  dirs[0], 1);
      check("pulse4_dir_second", dirs[1], 0);
    end else begin
      check("pulse4_dir_count", dirs.size(), 2);
    end

    // Reset mid-filter (filter counter at 2)
    clear_obs();
    quad_a = 1'b1;
    ticks(4);
    #2 reset = 1'b1;
    #1;
    check("rst_midfilter_step", step, 0);
    check("rst_midfilter_dir",  dir,  1);
    quad_a = 1'b0;
    ticks(2);
    reset = 1'b0;
    ticks(12);
    check("rst_midfilter_quiet", n_steps + n_errs, 0);

    // Reset mid-pulse of a down step
    clear_obs();
    quad_b = 1'b1;
    ticks(7);
    check("midpulse_step_high", step, 1);
    check("midpulse_dir_down",  dir,  0);
    #2 reset = 1'b1;
    #1;
    check("rst_midpulse_step", step, 0);
    check("rst_midpulse_dir",  dir,  1);
    check("rst_midpulse_err",  err,  0);
    quad_b = 1'b0;
    ticks(2);
    reset = 1'b0;
    clear_obs();
    ticks(12);
    check("rst_midpulse_quiet", n_steps + n_errs, 0);
    quad_a = 1'b1;
    ticks(10);
    check("post_reset_step", n_steps, 1);
    check("post_reset_dir",  last_dir, 1);

    check("step_err_exclusive", n_both, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
